// File: rtl/aes_round_stage.sv
// One registered AES-128 encryption round together with its key-expansion step.
// FINAL=1 builds the tenth round, which has no MixColumns.
module aes_round_stage #(
    parameter logic FINAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [3:0]   rc,
    input  logic [127:0] inputdata,
    input  logic [127:0] inkey,
    output logic [127:0] outkey,
    output logic [127:0] r_out,
    output logic         out_valid
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Inverse computed as a^254 = product of a^2..a^128, which also maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]   w_rcon;
    logic [31:0]  w_rot;
    logic [31:0]  w_subword;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_nextkey;
    logic [7:0]   w_sb  [16];
    logic [7:0]   w_sr  [16];
    logic [7:0]   w_mix [16];
    logic [127:0] w_round;

    logic [127:0] r_state;
    logic [127:0] r_key;
    logic         r_valid;

    always_comb begin
        w_rcon = 8'h00;
        case (rc)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_rot = {inkey[23:0], inkey[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key_sbox
            assign w_subword[31-8*gi -: 8] = sbox(w_rot[31-8*gi -: 8]);
        end
    endgenerate

    assign w_t       = w_subword ^ {w_rcon, 24'h000000};
    assign w_n0      = inkey[127:96] ^ w_t;
    assign w_n1      = w_n0 ^ inkey[95:64];
    assign w_n2      = w_n1 ^ inkey[63:32];
    assign w_n3      = w_n2 ^ inkey[31:0];
    assign w_nextkey = {w_n0, w_n1, w_n2, w_n3};

    // Byte 4c+r sits at row r, column c; ShiftRows pulls from column (c+r) mod 4.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
            assign w_sb[gi] = sbox(inputdata[127-8*gi -: 8]);
            assign w_sr[gi] = w_sb[SRC];
            assign w_round[127-8*gi -: 8] = w_mix[gi] ^ w_nextkey[127-8*gi -: 8];
        end

        if (FINAL) begin : g_no_mix
            for (genvar gi = 0; gi < 16; gi++) begin : g_pass
                assign w_mix[gi] = w_sr[gi];
            end
        end else begin : g_mix
            for (genvar gi = 0; gi < 4; gi++) begin : g_col
                logic [7:0] w_a0, w_a1, w_a2, w_a3;
                assign w_a0 = w_sr[4*gi];
                assign w_a1 = w_sr[4*gi+1];
                assign w_a2 = w_sr[4*gi+2];
                assign w_a3 = w_sr[4*gi+3];
                assign w_mix[4*gi]   = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
                assign w_mix[4*gi+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
                assign w_mix[4*gi+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
                assign w_mix[4*gi+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_state <= w_round;
                r_key   <= w_nextkey;
            end
        end
    end

    assign r_out     = r_state;
    assign outkey    = r_key;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_aes_round_stage.sv
// Self-checking bench for aes_round_stage: known-answer vectors, a ten-stage chain,
// random rounds against a table-based reference model, hold and asynchronous reset.
module tb_aes_round_stage;

    localparam logic [127:0] V1K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V1D = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V1NK = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] V1O = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] V2K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2D = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] V2NK = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] V2O = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] V3K = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] V3D = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] V3NK = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] V3O = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic [3:0]   rc;
    logic [127:0] inputdata, inkey;
    logic [127:0] key0, out0, key1, out1;
    logic         val0, val1;

    logic         ch_in_valid;
    logic [127:0] ch_in_data, ch_in_key;
    logic [127:0] ch_data [11];
    logic [127:0] ch_key  [11];
    logic         ch_valid [11];

    int n_vec = 0;
    int n_err = 0;
    int lat;

    logic [7:0]   exp_t  [256];
    logic [7:0]   log_t  [256];
    logic [7:0]   sbox_t [256];
    logic [127:0] e0_out, e0_key, e1_out, e1_key;

    aes_round_stage #(.FINAL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rc(rc),
        .inputdata(inputdata), .inkey(inkey),
        .outkey(key0), .r_out(out0), .out_valid(val0)
    );

    aes_round_stage #(.FINAL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rc(rc),
        .inputdata(inputdata), .inkey(inkey),
        .outkey(key1), .r_out(out1), .out_valid(val1)
    );

    assign ch_valid[0] = ch_in_valid;
    assign ch_data[0]  = ch_in_data;
    assign ch_key[0]   = ch_in_key;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_chain
            aes_round_stage #(.FINAL(gi == 9)) u_stage (
                .clk(clk), .rst_n(rst_n), .in_valid(ch_valid[gi]), .rc(4'(gi)),
                .inputdata(ch_data[gi]), .inkey(ch_key[gi]),
                .outkey(ch_key[gi+1]), .r_out(ch_data[gi+1]), .out_valid(ch_valid[gi+1])
            );
        end
    endgenerate

    function automatic logic [7:0] xt(input logic [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplication through log/antilog tables over generator 3.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
    endfunction

    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] inv;
        logic [7:0] sb;
        logic [7:0] c63;
        c63 = 8'h63;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = p;
            log_t[p] = 8'(i);
            p = p ^ xt(p);
        end
        exp_t[255] = 8'h01;
        log_t[0]   = 8'h00;
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : exp_t[(255 - int'(log_t[a])) % 255];
            for (int i = 0; i < 8; i++)
                sb[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sbox_t[a] = sb;
        end
    endtask

    task automatic model(input logic [127:0] d, input logic [127:0] k, input logic [3:0] r,
                         input logic fin, output logic [127:0] st, output logic [127:0] nk);
        logic [7:0]  rcon;
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  m [4][4];
        logic [7:0]  s [4][4];
        logic [7:0]  col [4];
        rcon = 8'h01;
        for (int i = 0; i < int'(r); i++) rcon = xt(rcon);
        if (r > 4'd9) rcon = 8'h00;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {w[3][23:0], w[3][31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        nk = {w[0], w[1], w[2], w[3]};
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                m[rr][c] = sbox_t[d[127-8*(4*c+rr) -: 8]];
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
                s[rr][c] = m[rr][(c+rr)%4];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                for (int rr = 0; rr < 4; rr++) col[rr] = s[rr][c];
                for (int rr = 0; rr < 4; rr++)
                    s[rr][c] = gmul(8'h02, col[rr]) ^ gmul(8'h03, col[(rr+1)%4])
                             ^ col[(rr+2)%4] ^ col[(rr+3)%4];
            end
        end
        st = '0;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                st[127-8*(4*c+rr) -: 8] = s[rr][c] ^ nk[127-8*(4*c+rr) -: 8];
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        $display("check %-16s observed %h expected %h", tag, obs, expv);
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic [127:0] d, input logic [127:0] k);
        logic [127:0] s, nk;
        @(negedge clk);
        in_valid  = v;
        rc        = r;
        inputdata = d;
        inkey     = k;
        if (v) begin
            model(d, k, r, 1'b0, s, nk);
            e0_out = s; e0_key = nk;
            model(d, k, r, 1'b1, s, nk);
            e1_out = s; e1_key = nk;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic v);
        chk({tag, " out0"}, out0, e0_out);
        chk({tag, " key0"}, key0, e0_key);
        chk({tag, " out1"}, out1, e1_out);
        chk({tag, " key1"}, key1, e1_key);
        chk({tag, " vld0"}, {127'b0, val0}, {127'b0, v});
        chk({tag, " vld1"}, {127'b0, val1}, {127'b0, v});
    endtask

    initial begin
        build_tables();
        rst_n = 1'b0; in_valid = 1'b0; rc = 4'd0; inputdata = '0; inkey = '0;
        ch_in_valid = 1'b0; ch_in_data = '0; ch_in_key = '0;
        e0_out = '0; e0_key = '0; e1_out = '0; e1_key = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0);
        chk("reset chain vld", {127'b0, ch_valid[10]}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back known-answer blocks, then an idle cycle that must hold.
        drive(1'b1, 4'd0, V1D, V1K);
        chk("kat1 outkey", key0, V1NK);
        chk("kat1 r_out", out0, V1O);
        check_all("kat1", 1'b1);
        drive(1'b1, 4'd0, V2D, V2K);
        chk("kat2 outkey", key0, V2NK);
        chk("kat2 r_out", out0, V2O);
        check_all("kat2", 1'b1);
        drive(1'b0, 4'( $urandom_range(0, 15)), {4{$urandom}}, {4{$urandom}});
        chk("hold r_out", out0, V2O);
        check_all("hold", 1'b0);

        drive(1'b1, 4'd9, V3D, V3K);
        chk("kat3 outkey", key1, V3NK);
        chk("kat3 r_out", out1, V3O);
        check_all("kat3", 1'b1);

        // Full ten-stage cipher.
        @(negedge clk);
        ch_in_valid = 1'b1;
        ch_in_data  = PT ^ V1K;
        ch_in_key   = V1K;
        @(negedge clk);
        ch_in_valid = 1'b0;
        ch_in_data  = {4{$urandom}};
        lat = 1;
        while (!ch_valid[10] && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("chain latency", 128'(lat), 128'd10);
        chk("chain cipher", ch_data[10], V3O);
        chk("chain key10", ch_key[10], V3NK);
        @(negedge clk);
        chk("chain vld drop", {127'b0, ch_valid[10]}, 128'd0);
        chk("chain hold", ch_data[10], V3O);

        for (int i = 0; i < 40; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            drive(v, 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom});
            check_all("rand", v);
        end

        // Asynchronous reset between edges with a block in flight.
        drive(1'b1, 4'd0, V1D, V1K);
        #2;
        rst_n = 1'b0;
        #1;
        e0_out = '0; e0_key = '0; e1_out = '0; e1_key = '0;
        check_all("async rst", 1'b0);
        @(negedge clk);
        in_valid = 1'b1; rc = 4'd0; inputdata = V2D; inkey = V2K;
        @(posedge clk);
        #1;
        check_all("rst held", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst outkey", key0, V2NK);
        chk("post rst r_out", out0, V2O);
        chk("post rst vld", {127'b0, val0}, 128'd1);
        @(negedge clk);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
